ctrl_if: RTL and testbench

- Instruction-fetch control stage. It is the producer end of the decode-stage interface: it drives the instruction word into decode and owns the decode stall.
- Consumes decode's registered memory-data-access cycle count. Arbitrates a single-port memory between instruction fetch and data access.
- Handles branch redirects by squashing the in-flight fetch.

---
 rtl/ctrl_if_if.sv | 26 ++
 rtl/ctrl_if.sv | 96 +++++++++
 tb/tb_ctrl_if.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_if_if.sv
// Fetch-stage bundle: decode-facing instruction/stall signals plus the
// single-port instruction memory port. master = fetch control, slave = its environment.
interface ctrl_if_if #(
  parameter int PC_W = 16
);
  logic [3:0]      i_mem_data_access;
  logic            i_branch_taken;
  logic [PC_W-1:0] i_branch_target;
  logic [15:0]     i_imem_rdata;
  logic [PC_W-1:0] o_imem_addr;
  logic            o_imem_en;
  logic            o_mem_bus_data;
  logic [15:0]     o_ir;
  logic [PC_W-1:0] o_pc;
  logic            o_stall;

  modport master (
    input  i_mem_data_access, i_branch_taken, i_branch_target, i_imem_rdata,
    output o_imem_addr, o_imem_en, o_mem_bus_data, o_ir, o_pc, o_stall
  );

  modport slave (
    output i_mem_data_access, i_branch_taken, i_branch_target, i_imem_rdata,
    input  o_imem_addr, o_imem_en, o_mem_bus_data, o_ir, o_pc, o_stall
  );
endinterface

// File: rtl/ctrl_if.sv
// Instruction-fetch control: drives decode's instruction word, arbitrates the
// single memory port between fetch and data access, squashes fetches on redirect.
//
//   state | meaning
//   FILL  | first cycle after reset, fetch issued, no word available yet
//   FETCH | streaming fetch, samples decode's data-access request
//   DATA  | memory port lent to data access, decode stalled
module ctrl_if #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_INSN = 16'h46C0
) (
  input logic   clk,
  input logic   rst,
  ctrl_if_if.master bus
);

  typedef enum logic [1:0] {FILL, FETCH, DATA} state_t;

  state_t          state_r, state_nx;
  logic [3:0]      stall_cnt_r, stall_cnt_nx;
  logic [PC_W-1:0] pc_r, pc_fetch_r, hold_pc_r;
  logic            fetch_valid_r, hold_valid_r;
  logic [15:0]     ir_hold_r;
  logic            imem_en, stall, branch;

  assign imem_en = (state_r != DATA);
  assign stall   = (state_r == DATA);
  assign branch  = bus.i_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      stall_cnt_r <= '0;
    end else begin
      state_r     <= state_nx;
      stall_cnt_r <= stall_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state_r;
    stall_cnt_nx = stall_cnt_r;
    case (state_r)
      FILL:  state_nx = FETCH;
      FETCH: begin
        if (bus.i_mem_data_access != 4'd0) begin
          state_nx     = DATA;
          stall_cnt_nx = bus.i_mem_data_access;
        end
      end
      DATA: begin
        stall_cnt_nx = stall_cnt_r - 4'd1;
        if (stall_cnt_r <= 4'd1) state_nx = FETCH;
      end
      default: state_nx = FILL;
    endcase
  end

  // A word returning while decode is stalled is parked so it is neither lost
  // nor presented twice; it is released on the first unstalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      pc_fetch_r    <= '0;
      hold_pc_r     <= '0;
      fetch_valid_r <= 1'b0;
      hold_valid_r  <= 1'b0;
      ir_hold_r     <= NOP_INSN;
    end else begin
      if (imem_en) pc_fetch_r <= pc_r;
      if (branch)       pc_r <= bus.i_branch_target;
      else if (imem_en) pc_r <= pc_r + PC_W'(2);
      fetch_valid_r <= imem_en & ~branch;
      if (branch) begin
        hold_valid_r <= 1'b0;
      end else if (stall && fetch_valid_r) begin
        ir_hold_r    <= bus.i_imem_rdata;
        hold_pc_r    <= pc_fetch_r;
        hold_valid_r <= 1'b1;
      end else if (!stall && !fetch_valid_r && hold_valid_r) begin
        hold_valid_r <= 1'b0;
      end
    end
  end

  assign bus.o_imem_addr    = pc_r;
  assign bus.o_imem_en      = imem_en;
  assign bus.o_mem_bus_data = stall;
  assign bus.o_stall        = stall;
  assign bus.o_ir = fetch_valid_r ? bus.i_imem_rdata :
                    (hold_valid_r ? ir_hold_r : NOP_INSN);
  assign bus.o_pc = fetch_valid_r ? pc_fetch_r :
                    (hold_valid_r ? hold_pc_r : '0);

endmodule

// File: tb/tb_ctrl_if.sv
// Directed bench for ctrl_if; memory returns ~addr one cycle after an enabled fetch.
module tb_ctrl_if;
  localparam logic [15:0] NOP = 16'h46C0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ctrl_if_if #(.PC_W(16)) bus ();

  ctrl_if #(.PC_W(16), .RESET_PC(16'h0000), .NOP_INSN(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_imem_en) bus.i_imem_rdata <= ~bus.o_imem_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return ~a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_mem_data_access = 4'd0;
    bus.i_branch_taken    = 1'b0;
    bus.i_branch_target   = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp += 5;
    if (bus.o_ir !== NOP) begin n_err++; $display("FAIL reset_ir got %h want %h", bus.o_ir, NOP); end
    if (bus.o_imem_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr got %h want 0000", bus.o_imem_addr); end
    if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.o_stall); end
    if (bus.o_imem_en !== 1'b1) begin n_err++; $display("FAIL reset_en got %b want 1", bus.o_imem_en); end
    if (bus.o_pc !== 16'h0) begin n_err++; $display("FAIL reset_pc got %h want 0000", bus.o_pc); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      n_cmp += 4;
      if (bus.o_imem_addr !== 16'(2*(k-1))) begin n_err++; $display("FAIL stream_addr c%0d got %h want %h", k, bus.o_imem_addr, 16'(2*(k-1))); end
      if (bus.o_ir !== mem_word(16'(2*(k-2)))) begin n_err++; $display("FAIL stream_ir c%0d got %h want %h", k, bus.o_ir, mem_word(16'(2*(k-2)))); end
      if (bus.o_pc !== 16'(2*(k-2))) begin n_err++; $display("FAIL stream_pc c%0d got %h want %h", k, bus.o_pc, 16'(2*(k-2))); end
      if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL stream_stall c%0d got %b want 0", k, bus.o_stall); end
    end
  endtask

  // Entered with pc_r = 8 in FETCH.
  task automatic test_data_access();
    bus.i_mem_data_access = 4'd2;
    tick();
    bus.i_mem_data_access = 4'd0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) tick();
      n_cmp += 6;
      if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL da_stall s%0d got %b want 1", k, bus.o_stall); end
      if (bus.o_mem_bus_data !== 1'b1) begin n_err++; $display("FAIL da_bus s%0d got %b want 1", k, bus.o_mem_bus_data); end
      if (bus.o_imem_en !== 1'b0) begin n_err++; $display("FAIL da_en s%0d got %b want 0", k, bus.o_imem_en); end
      if (bus.o_imem_addr !== 16'd10) begin n_err++; $display("FAIL da_addr s%0d got %h want 000a", k, bus.o_imem_addr); end
      if (bus.o_ir !== mem_word(16'd8)) begin n_err++; $display("FAIL da_ir s%0d got %h want %h", k, bus.o_ir, mem_word(16'd8)); end
      if (bus.o_pc !== 16'd8) begin n_err++; $display("FAIL da_pc s%0d got %h want 0008", k, bus.o_pc); end
    end
    tick();
    n_cmp += 4;
    if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL da_rel_stall got %b want 0", bus.o_stall); end
    if (bus.o_ir !== mem_word(16'd8)) begin n_err++; $display("FAIL da_rel_ir got %h want %h", bus.o_ir, mem_word(16'd8)); end
    if (bus.o_pc !== 16'd8) begin n_err++; $display("FAIL da_rel_pc got %h want 0008", bus.o_pc); end
    if (bus.o_imem_addr !== 16'd10) begin n_err++; $display("FAIL da_rel_addr got %h want 000a", bus.o_imem_addr); end
    tick();
    n_cmp += 2;
    if (bus.o_ir !== mem_word(16'd10)) begin n_err++; $display("FAIL da_next_ir got %h want %h", bus.o_ir, mem_word(16'd10)); end
    if (bus.o_pc !== 16'd10) begin n_err++; $display("FAIL da_next_pc got %h want 000a", bus.o_pc); end
    tick();
    n_cmp += 1;
    if (bus.o_ir !== mem_word(16'd12)) begin n_err++; $display("FAIL da_next2_ir got %h want %h", bus.o_ir, mem_word(16'd12)); end
  endtask

  // Entered with pc_r = 0x0E in FETCH.
  task automatic test_branch();
    tick();
    n_cmp += 1;
    if (bus.o_imem_addr !== 16'h10) begin n_err++; $display("FAIL br_pre_addr got %h want 0010", bus.o_imem_addr); end
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 16'h40;
    tick();
    bus.i_branch_taken  = 1'b0;
    n_cmp += 3;
    if (bus.o_ir !== NOP) begin n_err++; $display("FAIL br_bubble_ir got %h want %h", bus.o_ir, NOP); end
    if (bus.o_pc !== 16'h0) begin n_err++; $display("FAIL br_bubble_pc got %h want 0000", bus.o_pc); end
    if (bus.o_imem_addr !== 16'h40) begin n_err++; $display("FAIL br_addr got %h want 0040", bus.o_imem_addr); end
    tick();
    n_cmp += 3;
    if (bus.o_ir !== mem_word(16'h40)) begin n_err++; $display("FAIL br_tgt_ir got %h want %h", bus.o_ir, mem_word(16'h40)); end
    if (bus.o_pc !== 16'h40) begin n_err++; $display("FAIL br_tgt_pc got %h want 0040", bus.o_pc); end
    if (bus.o_imem_addr !== 16'h42) begin n_err++; $display("FAIL br_tgt_addr got %h want 0042", bus.o_imem_addr); end
  endtask

  task automatic test_branch_with_access();
    bus.i_branch_taken    = 1'b1;
    bus.i_branch_target   = 16'h80;
    bus.i_mem_data_access = 4'd3;
    tick();
    bus.i_branch_taken    = 1'b0;
    bus.i_mem_data_access = 4'd0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      n_cmp += 3;
      if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL bwa_stall s%0d got %b want 1", k, bus.o_stall); end
      if (bus.o_ir !== NOP) begin n_err++; $display("FAIL bwa_ir s%0d got %h want %h", k, bus.o_ir, NOP); end
      if (bus.o_imem_addr !== 16'h80) begin n_err++; $display("FAIL bwa_addr s%0d got %h want 0080", k, bus.o_imem_addr); end
    end
    tick();
    n_cmp += 4;
    if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL bwa_rel_stall got %b want 0", bus.o_stall); end
    if (bus.o_imem_en !== 1'b1) begin n_err++; $display("FAIL bwa_rel_en got %b want 1", bus.o_imem_en); end
    if (bus.o_imem_addr !== 16'h80) begin n_err++; $display("FAIL bwa_rel_addr got %h want 0080", bus.o_imem_addr); end
    if (bus.o_ir !== NOP) begin n_err++; $display("FAIL bwa_rel_ir got %h want %h", bus.o_ir, NOP); end
    tick();
    n_cmp += 2;
    if (bus.o_ir !== mem_word(16'h80)) begin n_err++; $display("FAIL bwa_tgt_ir got %h want %h", bus.o_ir, mem_word(16'h80)); end
    if (bus.o_pc !== 16'h80) begin n_err++; $display("FAIL bwa_tgt_pc got %h want 0080", bus.o_pc); end
  endtask

  task automatic test_held_access();
    int run;
    int total;
    bus.i_mem_data_access = 4'd2;
    tick();
    tick();
    n_cmp += 1;
    if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL held2_s2 got %b want 1", bus.o_stall); end
    tick();
    bus.i_mem_data_access = 4'd0;
    n_cmp += 1;
    if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL held2_release got %b want 0", bus.o_stall); end
    total = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total += int'(bus.o_stall);
    end
    n_cmp += 1;
    if (total !== 0) begin n_err++; $display("FAIL held2_restall got %0d want 0", total); end

    bus.i_mem_data_access = 4'd15;
    tick();
    run   = 0;
    total = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      if (k == 1) bus.i_mem_data_access = 4'd0;
      if (bus.o_stall === 1'b1 && run == k) run++;
      total += int'(bus.o_stall);
    end
    n_cmp += 2;
    if (run !== 15) begin n_err++; $display("FAIL stall15_run got %0d want 15", run); end
    if (total !== 15) begin n_err++; $display("FAIL stall15_total got %0d want 15", total); end
  endtask

  task automatic test_reset_mid_data();
    bus.i_mem_data_access = 4'd3;
    tick();
    bus.i_mem_data_access = 4'd0;
    tick();
    n_cmp += 1;
    if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL rmd_pre_stall got %b want 1", bus.o_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 5;
    if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL rmd_stall got %b want 0", bus.o_stall); end
    if (bus.o_imem_addr !== 16'h0) begin n_err++; $display("FAIL rmd_addr got %h want 0000", bus.o_imem_addr); end
    if (bus.o_ir !== NOP) begin n_err++; $display("FAIL rmd_ir got %h want %h", bus.o_ir, NOP); end
    if (bus.o_imem_en !== 1'b1) begin n_err++; $display("FAIL rmd_en got %b want 1", bus.o_imem_en); end
    if (bus.o_mem_bus_data !== 1'b0) begin n_err++; $display("FAIL rmd_bus got %b want 0", bus.o_mem_bus_data); end
    tick();
    n_cmp += 3;
    if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL rmd_after_stall got %b want 0", bus.o_stall); end
    if (bus.o_imem_addr !== 16'h2) begin n_err++; $display("FAIL rmd_after_addr got %h want 0002", bus.o_imem_addr); end
    if (bus.o_ir !== mem_word(16'h0)) begin n_err++; $display("FAIL rmd_after_ir got %h want %h", bus.o_ir, mem_word(16'h0)); end
  endtask

  task automatic test_pc_wrap();
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 16'hFFFE;
    tick();
    bus.i_branch_taken  = 1'b0;
    n_cmp += 1;
    if (bus.o_imem_addr !== 16'hFFFE) begin n_err++; $display("FAIL wrap_pre_addr got %h want fffe", bus.o_imem_addr); end
    tick();
    n_cmp += 3;
    if (bus.o_imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got %h want 0000", bus.o_imem_addr); end
    if (bus.o_ir !== mem_word(16'hFFFE)) begin n_err++; $display("FAIL wrap_ir got %h want %h", bus.o_ir, mem_word(16'hFFFE)); end
    if (bus.o_pc !== 16'hFFFE) begin n_err++; $display("FAIL wrap_pc got %h want fffe", bus.o_pc); end
    tick();
    n_cmp += 2;
    if (bus.o_ir !== mem_word(16'h0000)) begin n_err++; $display("FAIL wrap_next_ir got %h want %h", bus.o_ir, mem_word(16'h0000)); end
    if (bus.o_pc !== 16'h0000) begin n_err++; $display("FAIL wrap_next_pc got %h want 0000", bus.o_pc); end
  endtask

  initial begin
    bus.i_mem_data_access = 4'd0;
    bus.i_branch_taken    = 1'b0;
    bus.i_branch_target   = 16'h0000;
    bus.i_imem_rdata      = 16'h0000;
    test_reset();
    test_data_access();
    test_branch();
    test_branch_with_access();
    test_held_access();
    test_reset_mid_data();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
